// File: rtl/boid_pkg.sv
// Shared types and constants for the boid update unit.
package boid_pkg;

    // Default screen geometry
    localparam int DEFAULT_SCREEN_W = 640;
    localparam int DEFAULT_SCREEN_H = 480;

    // Field widths of the stored boid record
    localparam int BOID_X_W = 10;
    localparam int BOID_Y_W = 9;
    localparam int BOID_V_W = 4;

    // Power-on boid state: every boid starts at (100,100) moving (+1,+1)
    localparam int RESET_POS = 100;
    localparam int RESET_VEL = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_EMIT   = 2'd2
    } boid_state_e;

    typedef struct packed {
        logic        [BOID_X_W-1:0] x;
        logic        [BOID_Y_W-1:0] y;
        logic signed [BOID_V_W-1:0] dx;
        logic signed [BOID_V_W-1:0] dy;
    } boid_t;

endpackage

// File: rtl/boid_axis_step.sv
// One axis of boid motion: position += velocity, then bounce or wrap at the screen edge.
module boid_axis_step #(
    parameter int WIDTH     = 10,
    parameter int LIMIT     = 640,
    parameter int V_W       = 4,
    parameter int EDGE_MODE = 0
) (
    input  logic        [WIDTH-1:0] pos,
    input  logic signed [V_W-1:0]   vel,
    output logic        [WIDTH-1:0] new_pos,
    output logic signed [V_W-1:0]   new_vel
);

    // Two guard bits keep pos+vel exact (sign plus one bit of headroom)
    localparam int CW = WIDTH + 2;
    localparam logic signed [CW-1:0] LIM     = CW'(LIMIT);
    localparam logic signed [CW-1:0] LIM_M1  = CW'(LIMIT - 1);
    localparam logic signed [CW-1:0] MIRROR  = CW'(2 * (LIMIT - 1));

    logic signed [CW-1:0] sum;
    logic signed [CW-1:0] res;

    assign sum = $signed({2'b00, pos}) + $signed({{(CW - V_W){vel[V_W-1]}}, vel});

    // Edge handling; a single correction suffices because |vel| < LIMIT
    always_comb begin
        res     = sum;
        new_vel = vel;
        if (EDGE_MODE == 0) begin
            if (sum[CW-1]) begin
                res     = -sum;
                new_vel = -vel;
            end else if (sum > LIM_M1) begin
                res     = MIRROR - sum;
                new_vel = -vel;
            end
        end else begin
            if (sum[CW-1]) begin
                res = sum + LIM;
            end else if (sum > LIM_M1) begin
                res = sum - LIM;
            end
        end
    end

    assign new_pos = WIDTH'(res);

endmodule

// File: rtl/boid_update_unit.sv
// Boid update unit: on each frame_tick advances every boid one step, then
// streams their framebuffer addresses out over a valid/ready handshake.
module boid_update_unit
    import boid_pkg::*;
#(
    parameter int NUM_BOIDS  = 8,
    parameter int SCREEN_W   = DEFAULT_SCREEN_W,
    parameter int SCREEN_H   = DEFAULT_SCREEN_H,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int V_W        = 4,
    parameter int ADDR_W     = 19,
    parameter int EDGE_MODE  = 0,
    localparam int IDX_W     = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     init_valid,
    input  logic        [IDX_W-1:0]  init_idx,
    input  logic        [X_W-1:0]    init_x,
    input  logic        [Y_W-1:0]    init_y,
    input  logic signed [V_W-1:0]    init_dx,
    input  logic signed [V_W-1:0]    init_dy,
    output logic                     addr_valid,
    input  logic                     addr_ready,
    output logic        [ADDR_W-1:0] address,
    output logic        [IDX_W-1:0]  boid_idx,
    output logic        [X_W-1:0]    x_loc,
    output logic        [Y_W-1:0]    y_loc,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_BOIDS - 1);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_POS + SCREEN_W * RESET_POS);
    localparam boid_t RESET_BOID = '{
        x:  BOID_X_W'(RESET_POS),
        y:  BOID_Y_W'(RESET_POS),
        dx: BOID_V_W'(RESET_VEL),
        dy: BOID_V_W'(RESET_VEL)
    };

    boid_state_e        state_reg;
    boid_t              boids_reg [NUM_BOIDS];
    logic [IDX_W-1:0]   upd_idx_reg;
    logic [IDX_W-1:0]   emit_idx_reg;

    boid_t              cur_boid;
    boid_t              upd_boid;
    boid_t              init_boid;
    logic [X_W-1:0]     upd_x;
    logic [Y_W-1:0]     upd_y;
    logic signed [V_W-1:0] upd_dx;
    logic signed [V_W-1:0] upd_dy;

    logic [IDX_W-1:0]   emit_src_idx;
    logic [X_W-1:0]     emit_x;
    logic [Y_W-1:0]     emit_y;
    logic [ADDR_W-1:0]  emit_addr;

    assign busy     = (state_reg != ST_IDLE);
    assign cur_boid = boids_reg[upd_idx_reg];

    boid_axis_step #(
        .WIDTH(X_W), .LIMIT(SCREEN_W), .V_W(V_W), .EDGE_MODE(EDGE_MODE)
    ) u_step_x (
        .pos(X_W'(cur_boid.x)), .vel(V_W'(cur_boid.dx)),
        .new_pos(upd_x), .new_vel(upd_dx)
    );

    boid_axis_step #(
        .WIDTH(Y_W), .LIMIT(SCREEN_H), .V_W(V_W), .EDGE_MODE(EDGE_MODE)
    ) u_step_y (
        .pos(Y_W'(cur_boid.y)), .vel(V_W'(cur_boid.dy)),
        .new_pos(upd_y), .new_vel(upd_dy)
    );

    // Pack the stepped boid and the clamped load value into storage records
    always_comb begin
        upd_boid    = '{x: BOID_X_W'(upd_x), y: BOID_Y_W'(upd_y),
                        dx: BOID_V_W'(upd_dx), dy: BOID_V_W'(upd_dy)};
        init_boid.x  = (init_x > X_W'(SCREEN_W - 1)) ? BOID_X_W'(SCREEN_W - 1) : BOID_X_W'(init_x);
        init_boid.y  = (init_y > Y_W'(SCREEN_H - 1)) ? BOID_Y_W'(SCREEN_H - 1) : BOID_Y_W'(init_y);
        init_boid.dx = BOID_V_W'(init_dx);
        init_boid.dy = BOID_V_W'(init_dy);
    end

    // Select the boid to present next; forward the fresh step when boid 0
    // is also the one being written in the last UPDATE cycle
    always_comb begin
        emit_src_idx = '0;
        if (state_reg == ST_EMIT) begin
            emit_src_idx = emit_idx_reg + IDX_W'(1);
        end
        emit_x = X_W'(boids_reg[emit_src_idx].x);
        emit_y = Y_W'(boids_reg[emit_src_idx].y);
        if (state_reg == ST_UPDATE && upd_idx_reg == emit_src_idx) begin
            emit_x = upd_x;
            emit_y = upd_y;
        end
        emit_addr = ADDR_W'(emit_x) + ADDR_W'(SCREEN_W) * ADDR_W'(emit_y);
    end

    // Boid storage: loads are accepted only in IDLE, steps only in UPDATE
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_BOIDS; i++) begin
            if (reset) begin
                boids_reg[i] <= RESET_BOID;
            end else if (state_reg == ST_IDLE && init_valid && init_idx == IDX_W'(i)) begin
                boids_reg[i] <= init_boid;
            end else if (state_reg == ST_UPDATE && upd_idx_reg == IDX_W'(i)) begin
                boids_reg[i] <= upd_boid;
            end
        end
    end

    // Control FSM with registered handshake outputs and sticky overrun flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            upd_idx_reg  <= '0;
            emit_idx_reg <= '0;
            addr_valid   <= 1'b0;
            address      <= RESET_ADDR;
            boid_idx     <= '0;
            x_loc        <= X_W'(RESET_POS);
            y_loc        <= Y_W'(RESET_POS);
            overrun      <= 1'b0;
        end else begin
            if (frame_tick && state_reg != ST_IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state_reg)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state_reg   <= ST_UPDATE;
                        upd_idx_reg <= '0;
                    end
                end
                ST_UPDATE: begin
                    if (upd_idx_reg == LAST_IDX) begin
                        state_reg    <= ST_EMIT;
                        emit_idx_reg <= '0;
                        addr_valid   <= 1'b1;
                        address      <= emit_addr;
                        boid_idx     <= emit_src_idx;
                        x_loc        <= emit_x;
                        y_loc        <= emit_y;
                    end else begin
                        upd_idx_reg <= upd_idx_reg + IDX_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (addr_ready) begin
                        if (emit_idx_reg == LAST_IDX) begin
                            state_reg  <= ST_IDLE;
                            addr_valid <= 1'b0;
                        end else begin
                            emit_idx_reg <= emit_src_idx;
                            address      <= emit_addr;
                            boid_idx     <= emit_src_idx;
                            x_loc        <= emit_x;
                            y_loc        <= emit_y;
                        end
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    addr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boid_update_unit.sv
// Testbench: bounce and wrap instances driven in lockstep, checked against an integer model.
module tb_boid_update_unit;

    localparam int NB = 8;
    localparam int SW = 640;
    localparam int SH = 480;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic init_valid = 1'b0;
    logic addr_ready = 1'b1;
    logic [2:0] init_idx = '0;
    logic [9:0] init_x = '0;
    logic [8:0] init_y = '0;
    logic signed [3:0] init_dx = '0;
    logic signed [3:0] init_dy = '0;

    logic        addr_valid_b, addr_valid_w, busy_b, busy_w, overrun_b, overrun_w;
    logic [18:0] address_b, address_w;
    logic [2:0]  boid_idx_b, boid_idx_w;
    logic [9:0]  x_loc_b, x_loc_w;
    logic [8:0]  y_loc_b, y_loc_w;

    int checks = 0;
    int failures = 0;

    // model[m]: m=0 bounce, m=1 wrap
    int mx [2][NB];
    int my [2][NB];
    int mdx [2][NB];
    int mdy [2][NB];

    always #10 clock = ~clock;

    boid_update_unit #(.EDGE_MODE(0)) dut_bounce (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .init_valid(init_valid), .init_idx(init_idx), .init_x(init_x), .init_y(init_y),
        .init_dx(init_dx), .init_dy(init_dy),
        .addr_valid(addr_valid_b), .addr_ready(addr_ready), .address(address_b),
        .boid_idx(boid_idx_b), .x_loc(x_loc_b), .y_loc(y_loc_b),
        .busy(busy_b), .overrun(overrun_b)
    );

    boid_update_unit #(.EDGE_MODE(1)) dut_wrap (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .init_valid(init_valid), .init_idx(init_idx), .init_x(init_x), .init_y(init_y),
        .init_dx(init_dx), .init_dy(init_dy),
        .addr_valid(addr_valid_w), .addr_ready(addr_ready), .address(address_w),
        .boid_idx(boid_idx_w), .x_loc(x_loc_w), .y_loc(y_loc_w),
        .busy(busy_w), .overrun(overrun_w)
    );

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < NB; i++) begin
                mx[m][i] = 100; my[m][i] = 100; mdx[m][i] = 1; mdy[m][i] = 1;
            end
    endtask

    task automatic model_load(input int idx, input int x, input int y, input int dx, input int dy);
        for (int m = 0; m < 2; m++) begin
            mx[m][idx] = (x > SW - 1) ? SW - 1 : x;
            my[m][idx] = (y > SH - 1) ? SH - 1 : y;
            mdx[m][idx] = dx;
            mdy[m][idx] = dy;
        end
    endtask

    // One frame of motion for every boid, straight from the edge rules
    task automatic model_pass();
        int n;
        for (int i = 0; i < NB; i++) begin
            n = mx[0][i] + mdx[0][i];
            if (n < 0) begin mx[0][i] = -n; mdx[0][i] = -mdx[0][i]; end
            else if (n > SW - 1) begin mx[0][i] = 2 * (SW - 1) - n; mdx[0][i] = -mdx[0][i]; end
            else mx[0][i] = n;
            n = my[0][i] + mdy[0][i];
            if (n < 0) begin my[0][i] = -n; mdy[0][i] = -mdy[0][i]; end
            else if (n > SH - 1) begin my[0][i] = 2 * (SH - 1) - n; mdy[0][i] = -mdy[0][i]; end
            else my[0][i] = n;
            mx[1][i] = (((mx[1][i] + mdx[1][i]) % SW) + SW) % SW;
            my[1][i] = (((my[1][i] + mdy[1][i]) % SH) + SH) % SH;
        end
    endtask

    task automatic load_boid(input int idx, input int x, input int y, input int dx, input int dy);
        @(negedge clock);
        init_valid = 1'b1; init_idx = 3'(idx); init_x = 10'(x); init_y = 9'(y);
        init_dx = 4'(dx); init_dy = 4'(dy);
        model_load(idx, x, y, dx, dy);
        @(negedge clock);
        init_valid = 1'b0;
    endtask

    // Raise frame_tick for one cycle, optionally with a same-cycle load
    task automatic start_pass(input bit do_load, input int idx, input int x, input int y,
                              input int dx, input int dy);
        @(negedge clock);
        frame_tick = 1'b1;
        if (do_load) begin
            init_valid = 1'b1; init_idx = 3'(idx); init_x = 10'(x); init_y = 9'(y);
            init_dx = 4'(dx); init_dy = 4'(dy);
            model_load(idx, x, y, dx, dy);
        end
        model_pass();
    endtask

    // Walk a pass cycle by cycle; every valid cycle must show the model's next boid
    task automatic collect_pass(input int stall_start, input int stall_len,
                                input int busy_tick_at, input int abort_at);
        int k; int exp_idx; bit exp_valid;
        logic ov; logic ob; logic oo; logic [2:0] oi; logic [18:0] oa; logic [9:0] ox; logic [8:0] oy;
        k = 0; exp_idx = 0;
        while (exp_idx < NB) begin
            @(negedge clock);
            k++;
            frame_tick = (k == busy_tick_at);
            init_valid = (k == busy_tick_at);
            init_idx = 3'd0; init_x = 10'd5; init_y = 9'd5; init_dx = 4'sd0; init_dy = 4'sd0;
            if (k == abort_at) begin
                reset = 1'b1; frame_tick = 1'b0; init_valid = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                for (int m = 0; m < 2; m++) begin
                    ov = m ? addr_valid_w : addr_valid_b; ob = m ? busy_w : busy_b;
                    ox = m ? x_loc_w : x_loc_b; oy = m ? y_loc_w : y_loc_b;
                    checks++;
                    if (ov !== 1'b0 || ob !== 1'b0 || ox !== 10'd100 || oy !== 9'd100) begin
                        failures++;
                        $display("FAIL abort m=%0d got valid=%0b busy=%0b x=%0d y=%0d exp valid=0 busy=0 x=100 y=100",
                                 m, ov, ob, ox, oy);
                    end
                end
                model_reset();
                return;
            end
            addr_ready = !(k >= stall_start && k < stall_start + stall_len);
            exp_valid = (k >= NB + 1);
            for (int m = 0; m < 2; m++) begin
                ov = m ? addr_valid_w : addr_valid_b; ob = m ? busy_w : busy_b;
                oi = m ? boid_idx_w : boid_idx_b; oa = m ? address_w : address_b;
                ox = m ? x_loc_w : x_loc_b; oy = m ? y_loc_w : y_loc_b;
                checks++;
                if (ov !== exp_valid || ob !== 1'b1) begin
                    failures++;
                    $display("FAIL valid_busy m=%0d k=%0d got valid=%0b busy=%0b exp valid=%0b busy=1",
                             m, k, ov, ob, exp_valid);
                end
                if (exp_valid) begin
                    checks++;
                    if (oi !== 3'(exp_idx) || ox !== 10'(mx[m][exp_idx]) || oy !== 9'(my[m][exp_idx]) ||
                        oa !== 19'(mx[m][exp_idx] + SW * my[m][exp_idx])) begin
                        failures++;
                        $display("FAIL emit m=%0d k=%0d got idx=%0d x=%0d y=%0d addr=%0d exp idx=%0d x=%0d y=%0d addr=%0d",
                                 m, k, oi, ox, oy, oa, exp_idx, mx[m][exp_idx], my[m][exp_idx],
                                 mx[m][exp_idx] + SW * my[m][exp_idx]);
                    end
                end
            end
            if (exp_valid && addr_ready) exp_idx++;
        end
        @(negedge clock);
        frame_tick = 1'b0; init_valid = 1'b0; addr_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            ov = m ? addr_valid_w : addr_valid_b; ob = m ? busy_w : busy_b;
            ox = m ? x_loc_w : x_loc_b; oy = m ? y_loc_w : y_loc_b;
            oo = m ? overrun_w : overrun_b;
            checks++;
            if (ov !== 1'b0 || ob !== 1'b0 || ox !== 10'(mx[m][NB-1]) || oy !== 9'(my[m][NB-1]) ||
                oo !== (busy_tick_at > 0)) begin
                failures++;
                $display("FAIL idle_after m=%0d got valid=%0b busy=%0b x=%0d y=%0d ovr=%0b exp valid=0 busy=0 x=%0d y=%0d ovr=%0b",
                         m, ov, ob, ox, oy, oo, mx[m][NB-1], my[m][NB-1], busy_tick_at > 0);
            end
        end
    endtask

    task automatic test_reset();
        logic ov; logic ob; logic oo; logic [2:0] oi; logic [18:0] oa; logic [9:0] ox; logic [8:0] oy;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int m = 0; m < 2; m++) begin
            ov = m ? addr_valid_w : addr_valid_b; ob = m ? busy_w : busy_b; oo = m ? overrun_w : overrun_b;
            oi = m ? boid_idx_w : boid_idx_b; oa = m ? address_w : address_b;
            ox = m ? x_loc_w : x_loc_b; oy = m ? y_loc_w : y_loc_b;
            checks++;
            if (ov !== 1'b0 || ob !== 1'b0 || oo !== 1'b0) begin
                failures++;
                $display("FAIL reset_flags m=%0d got valid=%0b busy=%0b ovr=%0b exp 0 0 0", m, ov, ob, oo);
            end
            checks++;
            if (oa !== 19'd64100 || oi !== 3'd0 || ox !== 10'd100 || oy !== 9'd100) begin
                failures++;
                $display("FAIL reset_outputs m=%0d got addr=%0d idx=%0d x=%0d y=%0d exp 64100 0 100 100",
                         m, oa, oi, ox, oy);
            end
        end
        reset = 1'b0;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_reset_pass();
        start_pass(1'b0, 0, 0, 0, 0, 0);
        checks++;
        if (mx[0][0] + SW * my[0][0] != 64741) begin
            failures++;
            $display("FAIL reset_pass_model got=%0d exp=64741", mx[0][0] + SW * my[0][0]);
        end
        collect_pass(0, 0, -1, -1);
        $display("test_reset_pass done");
    endtask

    task automatic test_bounce_wrap();
        load_boid(3, 638, 100, 3, 0);
        load_boid(1, 2, 478, -5, 4);
        load_boid(6, 1000, 500, -1, -1);
        start_pass(1'b0, 0, 0, 0, 0, 0);
        collect_pass(0, 0, -1, -1);
        $display("test_bounce_wrap done");
    endtask

    task automatic test_backpressure();
        start_pass(1'b0, 0, 0, 0, 0, 0);
        collect_pass(NB + 3, 5, -1, -1);
        $display("test_backpressure done");
    endtask

    task automatic test_same_cycle_load();
        start_pass(1'b1, 0, 10, 50, 2, 0);
        collect_pass(0, 0, -1, -1);
        checks++;
        if (mx[0][0] != 12) begin
            failures++;
            $display("FAIL same_cycle_model got=%0d exp=12", mx[0][0]);
        end
        $display("test_same_cycle_load done");
    endtask

    task automatic test_random();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < NB; i++)
                load_boid(i, $urandom_range(SW - 1), $urandom_range(SH - 1),
                          int'($urandom_range(14)) - 7, int'($urandom_range(14)) - 7);
            for (int r = 0; r < 3; r++) begin
                start_pass(1'b0, 0, 0, 0, 0, 0);
                collect_pass(NB + 1 + int'($urandom_range(NB)), int'($urandom_range(4)), -1, -1);
            end
        end
        $display("test_random done");
    endtask

    task automatic test_overrun();
        logic ov;
        start_pass(1'b0, 0, 0, 0, 0, 0);
        collect_pass(0, 0, 3, -1);
        for (int c = 0; c < 2 * NB + 4; c++) begin
            @(negedge clock);
            for (int m = 0; m < 2; m++) begin
                ov = m ? addr_valid_w : addr_valid_b;
                checks++;
                if (ov !== 1'b0) begin
                    failures++;
                    $display("FAIL overrun_no_pass m=%0d c=%0d got valid=%0b exp 0", m, c, ov);
                end
            end
        end
        start_pass(1'b0, 0, 0, 0, 0, 0);
        collect_pass(0, 0, NB + 2, -1);
        $display("test_overrun done");
    endtask

    task automatic test_reset_mid_emit();
        start_pass(1'b0, 0, 0, 0, 0, 0);
        collect_pass(NB + 2, 3, -1, NB + 3);
        start_pass(1'b0, 0, 0, 0, 0, 0);
        collect_pass(0, 0, -1, -1);
        $display("test_reset_mid_emit done");
    endtask

    initial begin
        test_reset();
        test_reset_pass();
        test_bounce_wrap();
        test_backpressure();
        test_same_cycle_load();
        test_random();
        test_overrun();
        test_reset_mid_emit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
